vga_disp_pipe: RTL and testbench

Parametrised VGA display back-end that replaces the fixed 640x480 sync-plus-RGB-register top level.
- Generates the pixel tick and the h/v timing, and exports pixel coordinates to an external graphics generator.
- Delays sync and blanking to match the generator's pipeline latency, registers the final colour, and offers built-in test-pattern modes.
- Sits between any pixel-graphics block and the VGA connector pins.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_timing_gen.sv | 99 +++++++++
 rtl/vga_disp_pipe.sv | 157 +++++++++++++++
 tb/tb_vga_disp_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display back-end.
// - Default timing constants for 640x480@60 and 800x600@60.
// - Helper functions that derive the total line/frame lengths.
// - Output mode encoding and the record carried down the pixel delay line.
package vga_pkg;

    // 640x480@60 (25.175 MHz pixel clock)
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@60 (40 MHz pixel clock)
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    // One pixel's timing information as it travels towards the pins.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] h;
    } pix_info_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, horizontal/vertical counters,
// raw (active-high) sync flags, video_on and the frame start pulse.
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   p_tick_o           one-clk pixel enable
//   h_o, v_o           current pixel coordinates
//   video_on_o         coordinates lie inside the visible area
//   hsync_raw_o        h inside the horizontal sync interval (active high)
//   vsync_raw_o        v inside the vertical sync interval (active high)
//   frame_start_o      p_tick at h = v = 0
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic       p_tick_o,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       video_on_o,
    output logic       hsync_raw_o,
    output logic       vsync_raw_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
    end
    if (TICK_DIV < 1) begin : g_chk_div
        $error("vga_timing_gen: TICK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             tick;

    // Gating with rst keeps p_tick low while reset is held, which matters
    // for TICK_DIV = 1 where the divider compare is constantly true.
    assign tick = rst & (div_q == DIV_LAST);

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign p_tick_o      = tick;
    assign h_o           = h_q;
    assign v_o           = v_q;
    assign video_on_o    = (h_q < H_VIS) && (v_q < V_VIS);
    assign hsync_raw_o   = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign vsync_raw_o   = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    assign frame_start_o = tick && (h_q == 10'd0) && (v_q == 10'd0);

endmodule

// File: rtl/vga_disp_pipe.sv
// VGA display back-end: timing generation, coordinate export to an external
// graphics generator, a PIPE_LAT-tick delay line that realigns sync/blanking
// with the generator's colour, test-pattern selection and registered pins.
// Ports:
//   clk, rst                 system clock, asynchronous active-low reset
//   mode                     0 pass rgb_in, 1 colour bars, 2 fg_color, 3 black
//   fg_color                 solid colour for mode 2
//   rgb_in                   generator colour, PIPE_LAT ticks behind pixel_x/y
//   p_tick                   one-clk pixel enable
//   pixel_x, pixel_y         undelayed pixel coordinates
//   video_on                 undelayed visible-area flag
//   frame_start              one-clk pulse at the first pixel of a frame
//   hsync, vsync, rgb        registered pin outputs, mutually aligned
module vga_disp_pipe
    import vga_pkg::*;
#(
    parameter int   RGB_W    = 12,
    parameter int   TICK_DIV = 4,
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter int   PIPE_LAT = 2,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] fg_color,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             p_tick,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic             video_on,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);

    localparam int FIELD_W = RGB_W / 3;
    localparam logic [9:0] BAR_DIV = 10'(H_ACTIVE / 8);

    if (RGB_W % 3 != 0 || RGB_W < 3) begin : g_chk_rgb
        $error("vga_disp_pipe: RGB_W must be a positive multiple of 3");
    end
    if (H_ACTIVE < 8) begin : g_chk_bars
        $error("vga_disp_pipe: H_ACTIVE must allow eight colour bars");
    end
    if (PIPE_LAT < 0) begin : g_chk_lat
        $error("vga_disp_pipe: PIPE_LAT must not be negative");
    end

    logic      hs_raw, vs_raw;
    pix_info_t pix_raw, pix_dly;

    vga_timing_gen #(
        .TICK_DIV (TICK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .p_tick_o      (p_tick),
        .h_o           (pixel_x),
        .v_o           (pixel_y),
        .video_on_o    (video_on),
        .hsync_raw_o   (hs_raw),
        .vsync_raw_o   (vs_raw),
        .frame_start_o (frame_start)
    );

    assign pix_raw = '{hs: hs_raw, vs: vs_raw, von: video_on, h: pixel_x};

    // Delay line: reset contents are the inactive state (no sync, blanked).
    if (PIPE_LAT == 0) begin : g_no_delay
        assign pix_dly = pix_raw;
    end else begin : g_delay
        pix_info_t line_q [PIPE_LAT];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                line_q <= '{default: '0};
            end else if (p_tick) begin
                line_q[0] <= pix_raw;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    line_q[i] <= line_q[i-1];
                end
            end
        end

        assign pix_dly = line_q[PIPE_LAT-1];
    end

    mode_e            mode_q, mode_eff;
    logic [9:0]       bar_idx;
    logic [2:0]       bar_k;
    logic [RGB_W-1:0] colour_sel;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    always_comb begin
        // The new frame's mode is forwarded on the frame_start tick so that
        // with PIPE_LAT = 0 pixel 0 already uses it; with PIPE_LAT > 0 the
        // pixels leaving on that tick are vertical blanking anyway.
        mode_eff = frame_start ? mode_e'(mode) : mode_q;

        bar_idx = pix_dly.h / BAR_DIV;
        bar_k   = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];

        colour_sel = '0;
        case (mode_eff)
            MODE_PASS:  colour_sel = rgb_in;
            MODE_BARS:  colour_sel = {{FIELD_W{bar_k[2]}}, {FIELD_W{bar_k[1]}}, {FIELD_W{bar_k[0]}}};
            MODE_SOLID: colour_sel = fg_color;
            default:    colour_sel = '0;
        endcase

        rgb_d = pix_dly.von ? colour_sel : '0;
        hs_d  = pix_dly.hs ? SYNC_POL : ~SYNC_POL;
        vs_d  = pix_dly.vs ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_BLACK;
            rgb_q  <= '0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
        end else begin
            if (frame_start) begin
                mode_q <= mode_e'(mode);
            end
            if (p_tick) begin
                rgb_q <= rgb_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
            end
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hs_q;
    assign vsync = vs_q;

endmodule

// File: tb/tb_vga_disp_pipe.sv
`timescale 1ns/1ps
module tb_vga_disp_pipe;

    // Instance 0: divided tick, two-tick generator latency, active-low sync.
    localparam int   TD0 = 4, PL0 = 2, W0 = 12;
    localparam int   HA0 = 32, HFP0 = 4, HS0 = 6, HBP0 = 6;
    localparam int   VA0 = 6, VFP0 = 2, VS0 = 2, VBP0 = 3;
    localparam logic POL0 = 1'b0;
    // Instance 1: tick every clock, no generator latency, active-high sync.
    localparam int   TD1 = 1, PL1 = 0, W1 = 6;
    localparam int   HA1 = 16, HFP1 = 2, HS1 = 3, HBP1 = 3;
    localparam int   VA1 = 4, VFP1 = 1, VS1 = 1, VBP1 = 2;
    localparam logic POL1 = 1'b1;

    typedef struct packed {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        von;
        logic        pt;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [1:0]    next_mode = 2'd0;
    logic [11:0]   fg_color = '0;
    logic [W0-1:0] rgb_in0 = '0;
    logic [W1-1:0] rgb_in1 = '0;

    logic          p_tick0, video_on0, frame_start0, hsync0, vsync0;
    logic [9:0]    pixel_x0, pixel_y0;
    logic [W0-1:0] rgb0;
    logic          p_tick1, video_on1, frame_start1, hsync1, vsync1;
    logic [9:0]    pixel_x1, pixel_y1;
    logic [W1-1:0] rgb1;

    always #5 clk = ~clk;

    vga_disp_pipe #(
        .RGB_W(W0), .TICK_DIV(TD0),
        .H_ACTIVE(HA0), .H_FP(HFP0), .H_SYNC(HS0), .H_BP(HBP0),
        .V_ACTIVE(VA0), .V_FP(VFP0), .V_SYNC(VS0), .V_BP(VBP0),
        .PIPE_LAT(PL0), .SYNC_POL(POL0)
    ) dut0 (
        .clk(clk), .rst(rst), .mode(mode), .fg_color(fg_color[W0-1:0]), .rgb_in(rgb_in0),
        .p_tick(p_tick0), .pixel_x(pixel_x0), .pixel_y(pixel_y0), .video_on(video_on0),
        .frame_start(frame_start0), .hsync(hsync0), .vsync(vsync0), .rgb(rgb0)
    );

    vga_disp_pipe #(
        .RGB_W(W1), .TICK_DIV(TD1),
        .H_ACTIVE(HA1), .H_FP(HFP1), .H_SYNC(HS1), .H_BP(HBP1),
        .V_ACTIVE(VA1), .V_FP(VFP1), .V_SYNC(VS1), .V_BP(VBP1),
        .PIPE_LAT(PL1), .SYNC_POL(POL1)
    ) dut1 (
        .clk(clk), .rst(rst), .mode(mode), .fg_color(fg_color[W1-1:0]), .rgb_in(rgb_in1),
        .p_tick(p_tick1), .pixel_x(pixel_x1), .pixel_y(pixel_y1), .video_on(video_on1),
        .frame_start(frame_start1), .hsync(hsync1), .vsync(vsync1), .rgb(rgb1)
    );

    // Reference model: pixel index arithmetic over ticks since reset release.
    int   td[2]  = '{TD0, TD1};
    int   pl[2]  = '{PL0, PL1};
    int   wd[2]  = '{W0, W1};
    int   ha[2]  = '{HA0, HA1};
    int   hfp[2] = '{HFP0, HFP1};
    int   hsw[2] = '{HS0, HS1};
    int   va[2]  = '{VA0, VA1};
    int   vfp[2] = '{VFP0, VFP1};
    int   vsw[2] = '{VS0, VS1};
    int   ht[2]  = '{HA0 + HFP0 + HS0 + HBP0, HA1 + HFP1 + HS1 + HBP1};
    int   fr[2]  = '{(HA0 + HFP0 + HS0 + HBP0) * (VA0 + VFP0 + VS0 + VBP0),
                     (HA1 + HFP1 + HS1 + HBP1) * (VA1 + VFP1 + VS1 + VBP1)};
    logic pol[2] = '{POL0, POL1};

    int          n_m[2];
    int          lmode[2];
    logic        hs_m[2], vs_m[2];
    logic [11:0] rgb_m[2];

    obs_t sb0[$];
    obs_t sb1[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [11:0] colour(input int i, input int m, input int h,
                                           input logic [11:0] f, input logic [11:0] rin);
        int w, mask, full, k, r, g, b;
        w    = wd[i] / 3;
        mask = (1 << wd[i]) - 1;
        full = (1 << w) - 1;
        case (m)
            0: return 12'(int'(rin) & mask);
            1: begin
                k = h / (ha[i] / 8);
                if (k > 7) k = 7;
                r = ((k / 4) % 2 == 1) ? full : 0;
                g = ((k / 2) % 2 == 1) ? full : 0;
                b = (k % 2 == 1) ? full : 0;
                return 12'((r << (2 * w)) | (g << w) | b);
            end
            2: return 12'(int'(f) & mask);
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_reset(input int i);
        n_m[i]   = 0;
        lmode[i] = 3;
        hs_m[i]  = ~pol[i];
        vs_m[i]  = ~pol[i];
        rgb_m[i] = '0;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input int i, input logic [1:0] md, input logic [11:0] f,
                              input logic [11:0] rin);
        int k, p, q, h, v;
        n_m[i]++;
        if (n_m[i] % td[i] != 0) return;
        k = n_m[i] / td[i] - 1;
        if (k % fr[i] == 0) lmode[i] = int'(md);
        p = k - pl[i];
        if (p < 0) begin
            hs_m[i]  = ~pol[i];
            vs_m[i]  = ~pol[i];
            rgb_m[i] = '0;
            return;
        end
        q = p % fr[i];
        h = q % ht[i];
        v = q / ht[i];
        hs_m[i]  = (h >= ha[i] + hfp[i] && h < ha[i] + hfp[i] + hsw[i]) ? pol[i] : ~pol[i];
        vs_m[i]  = (v >= va[i] + vfp[i] && v < va[i] + vfp[i] + vsw[i]) ? pol[i] : ~pol[i];
        rgb_m[i] = (h < ha[i] && v < va[i]) ? colour(i, lmode[i], h, f, rin) : 12'h000;
    endtask

    function automatic obs_t model_obs(input int i);
        obs_t o;
        int   q;
        q     = (n_m[i] / td[i]) % fr[i];
        o.px  = 10'(q % ht[i]);
        o.py  = 10'(q / ht[i]);
        o.von = (q % ht[i] < ha[i]) && (q / ht[i] < va[i]);
        o.pt  = ((n_m[i] + 1) % td[i]) == 0;
        o.fs  = o.pt && (q == 0);
        o.hs  = hs_m[i];
        o.vs  = vs_m[i];
        o.rgb = rgb_m[i];
        return o;
    endfunction

    function automatic obs_t reset_obs(input int i);
        obs_t o;
        o.px  = '0;
        o.py  = '0;
        o.von = 1'b1;
        o.pt  = 1'b0;
        o.fs  = 1'b0;
        o.hs  = ~pol[i];
        o.vs  = ~pol[i];
        o.rgb = '0;
        return o;
    endfunction

    // kind: 0 run, 1 hold reset, 2 release reset, 3 assert reset just after the next edge
    task automatic step(input int kind);
        obs_t e0, e1;
        @(negedge clk);
        mode     = next_mode;
        rgb_in0  = W0'($urandom);
        rgb_in1  = W1'($urandom);
        fg_color = 12'($urandom);
        if (kind == 2) begin
            rst = 1'b1;
            model_reset(0);
            model_reset(1);
        end
        if (kind == 0 || kind == 2) begin
            model_edge(0, mode, fg_color, 12'(rgb_in0));
            model_edge(1, mode, fg_color, 12'(rgb_in1));
            e0 = model_obs(0);
            e1 = model_obs(1);
        end else begin
            model_reset(0);
            model_reset(1);
            e0 = reset_obs(0);
            e1 = reset_obs(1);
        end
        sb0.push_back(e0);
        sb1.push_back(e1);
        if (kind == 3) begin
            @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    task automatic compare(input int i, input obs_t a, input obs_t e);
        nvec++;
        if (a !== e) begin
            nerr++;
            if (nerr <= 20)
                $display("FAIL inst%0d_pins @%0t: got px=%0d py=%0d von=%b pt=%b fs=%b hs=%b vs=%b rgb=%h, want px=%0d py=%0d von=%b pt=%b fs=%b hs=%b vs=%b rgb=%h",
                         i, $time, a.px, a.py, a.von, a.pt, a.fs, a.hs, a.vs, a.rgb,
                         e.px, e.py, e.von, e.pt, e.fs, e.hs, e.vs, e.rgb);
        end
    endtask

    // Monitor: samples the pins 2 ns after each rising edge.
    initial begin
        obs_t a0, a1;
        forever begin
            @(posedge clk);
            #2;
            a0 = '{px: pixel_x0, py: pixel_y0, von: video_on0, pt: p_tick0, fs: frame_start0,
                   hs: hsync0, vs: vsync0, rgb: 12'(rgb0)};
            a1 = '{px: pixel_x1, py: pixel_y1, von: video_on1, pt: p_tick1, fs: frame_start1,
                   hs: hsync1, vs: vsync1, rgb: 12'(rgb1)};
            if (sb0.size() > 0) compare(0, a0, sb0.pop_front());
            if (sb1.size() > 0) compare(1, a1, sb1.pop_front());
        end
    end

    initial begin
        int md_seq[8] = '{0, 2, 1, 3, 0, 1, 2, 0};
        model_reset(0);
        model_reset(1);
        repeat (3) step(1);
        step(2);
        for (int s = 0; s < 8; s++) begin
            int len;
            len       = $urandom_range(1500, 2500);
            next_mode = 2'(md_seq[s]);
            for (int j = 0; j < len; j++) begin
                if ((s == 3 || s == 6) && j == len / 2) begin
                    step(3);
                    repeat ($urandom_range(1, 4)) step(1);
                    step(2);
                end else begin
                    step(0);
                end
            end
        end
        @(posedge clk);
        #3;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", sb0.size(), sb1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
